// File: rtl/ysyx_25060170_mem_arbiter.sv
// IFU/LSU arbiter for the single memory port: one outstanding transaction, IDLE->REQ->RESP.
// Define YSYX_25060170_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module ysyx_25060170_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_len,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_len,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  logic        owner_lsu;
  logic [31:0] cnt;
  logic        grant_lsu;
  logic        grant_ifu;

`ifdef YSYX_25060170_ARB_RR_EN
  logic last_grant;  // 0 = IFU granted last, 1 = LSU granted last

  always_comb begin
    grant_lsu = lsu_req_valid;
    if (lsu_req_valid && ifu_req_valid) grant_lsu = last_grant == 1'b0;
  end
`else
  always_comb begin
    grant_lsu = lsu_req_valid;
  end
`endif

  assign grant_ifu = ifu_req_valid && !grant_lsu;

  // Ready is held low during reset so every output reads 0 while rst is asserted.
  assign ifu_req_ready = rst && (state == IDLE) && grant_ifu;
  assign lsu_req_ready = rst && (state == IDLE) && grant_lsu;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      owner_lsu      <= 1'b0;
      cnt            <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_len        <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
      resp_err       <= 1'b0;
`ifdef YSYX_25060170_ARB_RR_EN
      last_grant     <= 1'b0;
`endif
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      resp_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            owner_lsu     <= 1'b1;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_len       <= lsu_len;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef YSYX_25060170_ARB_RR_EN
            last_grant    <= 1'b1;
`endif
          end else if (grant_ifu) begin
            owner_lsu     <= 1'b0;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_len       <= 3'd4;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef YSYX_25060170_ARB_RR_EN
            last_grant    <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (mem_resp_valid) begin
            if (owner_lsu) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= mem_wen ? '0 : mem_rdata;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= mem_rdata;
            end
            cnt   <= '0;
            state <= IDLE;
          end else if (TIMEOUT != 0 && cnt == TIMEOUT - 1) begin
            // Firing one count early puts the error pulse exactly TIMEOUT cycles after entering RESP.
            if (owner_lsu) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= DATA_W'(32'hDEADBEEF);
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= DATA_W'(32'hDEADBEEF);
            end
            resp_err <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
